line_window_gen: RTL
====================

Name: line_window_gen

Overview:
- Streaming 3x3 window generator that sits directly upstream of the 3x3 convolution stage.
- Accepts a raster-order 8-bit greyscale pixel stream, one pixel per valid cycle, with no backpressure.
- Buffers two full lines and emits, once per accepted pixel at a valid position, a packed 72-bit 3x3 neighbourhood with a valid strobe that drives the convolver's 72-bit window and valid inputs directly.

Parameters:
- IMG_WIDTH, 512, pixels per line; range 3..4096; sets line-buffer depth.
- IMG_HEIGHT, 512, lines per frame; range 3..4096.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rstn  in  1  synchronous active-low reset.
- i_pixel_data  in  8  input pixel.
- i_pixel_data_valid  in  1  input pixel is accepted this cycle.
- i_sof  in  1  start of frame; qualified by i_pixel_data_valid.
- o_pixel_data  out  72  packed 3x3 window.
- o_pixel_data_valid  out  1  o_pixel_data holds a new window.
- o_frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
- One clock (i_clk). Reset is synchronous and active-low on i_rstn.
- Reset values: o_pixel_data=0, o_pixel_data_valid=0, o_frame_done=0, column counter x=0, row counter y=0.
- Line-buffer RAM contents are not cleared by reset; they are never exposed because output validity is gated.
- Position counters:
  - The accepted pixel takes position (x,y). After acceptance, x increments.
  - At x=IMG_WIDTH-1, x wraps to 0 and y increments.
  - At (IMG_WIDTH-1, IMG_HEIGHT-1), both counters wrap to 0 and o_frame_done pulses on the next cycle.
- i_sof=1 with valid: that pixel is (0,0) regardless of the counters. The counters continue from (1,0).
  - A mid-frame i_sof abandons the current frame with no o_frame_done.
  - An i_sof on a pixel that would otherwise be the last of the frame is also treated as (0,0), so no o_frame_done.
  - i_sof without valid is ignored.
- Storage:
  - Two line buffers of IMG_WIDTH bytes hold rows y-1 and y-2, addressed by x and read/written in the same cycle (read-before-write).
  - A 3-column shift register holds the last three columns of the 3 rows.
- Window packing: byte k = o_pixel_data[k*8+:8], with r=k/3 and c=k%3.
  - Byte k holds the pixel at image row y-2+r, column x-2+c.
  - Byte 0 is top-left (x-2,y-2). Byte 4 is the centre (x-1,y-1). Byte 8 is the newest pixel (x,y).
- Output validity:
  - o_pixel_data_valid=1 exactly one cycle after an accepted pixel with x>=2 and y>=2, otherwise 0.
  - Each frame therefore yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows. There is no padding.
  - Windows never span a line wrap or a frame boundary.
- Idle cycles (valid=0): counters and buffers hold, o_pixel_data_valid=0, o_pixel_data holds its last value.
- Latency: 1 cycle from pixel acceptance to window output. Sustained throughput is 1 window per cycle.
- Reset mid-operation: outputs are 0 on the cycle after reset is sampled low. The first pixel accepted after reset is (0,0).
- No backpressure: the consumer must accept every window.

Optional Feature:
- Macro: WINDOW_POS_EN.
- Defined:
  - Adds output o_win_x (width clog2(IMG_WIDTH)) and output o_win_y (width clog2(IMG_HEIGHT)).
  - They give the window centre (x-1,y-1) and are registered alongside o_pixel_data, with the same valid.
  - Reset value 0; they hold their value when valid=0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan (IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = y*16+x):
- Reset, then a continuous full frame -> exactly 24 valid windows.
  - The first window appears the cycle after pixel (2,2), with bytes 0..8 = 00,01,02,10,11,12,20,21,22.
  - The last window has bytes 0..8 = 35,36,37,45,46,47,55,56,57.
- Same frame with random idle gaps (valid=0 for 1..5 cycles) -> the same 24 windows in the same order.
  - Valid is high only on the cycle after an accepted pixel.
  - o_pixel_data is stable during gaps.
- Two back-to-back frames -> a single o_frame_done pulse the cycle after pixel (7,5).
  - Frame-2 rows 0..1 produce no valid.
  - The first frame-2 window equals the first frame-1 window.
- i_sof asserted at the would-be pixel (4,3) -> that pixel becomes (0,0), no o_frame_done.
  - The next valid window follows the new (2,2), with no bytes from the abandoned frame.
- i_rstn low for 1 cycle during row 3 -> o_pixel_data_valid=0 and o_pixel_data=0 the next cycle.
  - The next accepted pixel is (0,0), and the first window follows pixel (2,2).
- With WINDOW_POS_EN defined, a full frame -> the first window has o_win_x=1, o_win_y=1 and the last has o_win_x=6, o_win_y=4.

Source files
------------

// File: rtl/line_window_gen_if.sv
// Pixel-stream in / 3x3-window out bundle for line_window_gen.
// Define WINDOW_POS_EN to carry the window-centre coordinates as well.
interface line_window_gen_if #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
);
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        i_sof;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;
`ifdef WINDOW_POS_EN
    logic [$clog2(IMG_WIDTH)-1:0]  o_win_x;
    logic [$clog2(IMG_HEIGHT)-1:0] o_win_y;
`endif

    modport master (
        output i_pixel_data, i_pixel_data_valid, i_sof,
        input  o_pixel_data, o_pixel_data_valid, o_frame_done
`ifdef WINDOW_POS_EN
        , input o_win_x, o_win_y
`endif
    );

    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_sof,
        output o_pixel_data, o_pixel_data_valid, o_frame_done
`ifdef WINDOW_POS_EN
        , output o_win_x, o_win_y
`endif
    );
endinterface

// File: rtl/line_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3-column shift register.
// Define WINDOW_POS_EN to add registered window-centre coordinates (o_win_x/o_win_y).
module line_window_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    line_window_gen_if.slave bus
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    logic [XW-1:0] x_reg, x_next, x_eff;
    logic [YW-1:0] y_reg, y_next, y_eff;
    logic          accept, win_ok, last_pix;

    // col_reg[c][r]: column c (0 = oldest, x-2) of row r (0 = top, y-2)
    logic [2:0][2:0][7:0] col_reg;
    logic                 valid_reg;
    logic                 done_reg;

    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb2_mem [IMG_WIDTH];
    logic [7:0] row1_pix, row2_pix;

    assign accept = bus.i_pixel_data_valid;
    // A start-of-frame pixel is (0,0) no matter where the counters were.
    assign x_eff    = bus.i_sof ? '0 : x_reg;
    assign y_eff    = bus.i_sof ? '0 : y_reg;
    assign win_ok   = (x_eff >= XW'(2)) && (y_eff >= YW'(2));
    assign last_pix = (x_eff == XW'(IMG_WIDTH - 1)) && (y_eff == YW'(IMG_HEIGHT - 1));

    always_comb begin
        x_next = x_eff + XW'(1);
        y_next = y_eff;
        if (x_eff == XW'(IMG_WIDTH - 1)) begin
            x_next = '0;
            y_next = last_pix ? '0 : y_eff + YW'(1);
        end
    end

    // Read-before-write: the same address returns the previous line's pixel
    // while the newer row is pushed down one buffer.
    assign row1_pix = lb1_mem[x_eff];
    assign row2_pix = lb2_mem[x_eff];

    always_ff @(posedge i_clk) begin
        if (i_rstn && accept) begin
            lb1_mem[x_eff] <= bus.i_pixel_data;
            lb2_mem[x_eff] <= row1_pix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            x_reg     <= '0;
            y_reg     <= '0;
            col_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            valid_reg <= accept && win_ok;
            done_reg  <= accept && last_pix;
            if (accept) begin
                x_reg      <= x_next;
                y_reg      <= y_next;
                col_reg[0] <= col_reg[1];
                col_reg[1] <= col_reg[2];
                col_reg[2] <= {bus.i_pixel_data, row1_pix, row2_pix};
            end
        end
    end

    // Byte k of the window is row k/3, column k%3 of the shift register.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_pack
            assign bus.o_pixel_data[gi*8 +: 8] = col_reg[gi % 3][gi / 3];
        end
    endgenerate

    assign bus.o_pixel_data_valid = valid_reg;
    assign bus.o_frame_done       = done_reg;

`ifdef WINDOW_POS_EN
    logic [XW-1:0] win_x_reg;
    logic [YW-1:0] win_y_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            win_x_reg <= '0;
            win_y_reg <= '0;
        end else if (accept && win_ok) begin
            win_x_reg <= x_eff - XW'(1);
            win_y_reg <= y_eff - YW'(1);
        end
    end

    assign bus.o_win_x = win_x_reg;
    assign bus.o_win_y = win_y_reg;
`endif
endmodule
